// File: rtl/maze_pkg.sv
// Shared types and heading helpers for the wall-following maze walker.
package maze_pkg;

    typedef enum logic [2:0] {IDLE, MARK, PROBE, EVAL, DONE, FAIL} state_t;

    localparam logic [1:0] DIR_E = 2'd0;
    localparam logic [1:0] DIR_N = 2'd1;
    localparam logic [1:0] DIR_W = 2'd2;
    localparam logic [1:0] DIR_S = 2'd3;

    // Headings are numbered counter-clockwise, so a left turn is +1.
    function automatic logic [1:0] turn_left(input logic [1:0] h);
        return h + 2'd1;
    endfunction

    function automatic logic [1:0] turn_right(input logic [1:0] h);
        return h - 2'd1;
    endfunction

    // hand: 0 = right-hand rule, 1 = left-hand rule
    function automatic logic [1:0] probe_dir(input logic [1:0] h, input logic hand,
                                             input logic [1:0] attempt);
        case (attempt)
            2'd0:    return hand ? turn_left(h) : turn_right(h);
            2'd1:    return h;
            2'd2:    return hand ? turn_right(h) : turn_left(h);
            default: return h + 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/maze_dir_sel.sv
// Candidate-cell selector: neighbour for the current probe attempt and
// whether that neighbour lies outside the grid.
module maze_dir_sel
    import maze_pkg::*;
#(
    parameter int MAZE_WIDTH = 6,
    parameter int MAZE_ROWS  = 64,
    parameter int MAZE_COLS  = 64
) (
    input  logic [MAZE_WIDTH-1:0] cur_row,
    input  logic [MAZE_WIDTH-1:0] cur_col,
    input  logic [1:0]            heading,
    input  logic [1:0]            attempt,
    input  logic                  hand,
    output logic [MAZE_WIDTH-1:0] cand_row,
    output logic [MAZE_WIDTH-1:0] cand_col,
    output logic [1:0]            cand_dir,
    output logic                  off_grid
);

    localparam logic [MAZE_WIDTH-1:0] LAST_ROW = MAZE_WIDTH'(MAZE_ROWS - 1);
    localparam logic [MAZE_WIDTH-1:0] LAST_COL = MAZE_WIDTH'(MAZE_COLS - 1);
    localparam logic [MAZE_WIDTH-1:0] ONE      = MAZE_WIDTH'(1);
    localparam logic [MAZE_WIDTH-1:0] ZERO     = '0;

    always_comb begin
        cand_dir = probe_dir(heading, hand, attempt);
        cand_row = cur_row;
        cand_col = cur_col;
        off_grid = 1'b0;
        case (cand_dir)
            DIR_E: begin
                off_grid = (cur_col >= LAST_COL);
                cand_col = cur_col + ONE;
            end
            DIR_N: begin
                off_grid = (cur_row == ZERO);
                cand_row = cur_row - ONE;
            end
            DIR_W: begin
                off_grid = (cur_col == ZERO);
                cand_col = cur_col - ONE;
            end
            default: begin
                off_grid = (cur_row >= LAST_ROW);
                cand_row = cur_row + ONE;
            end
        endcase
    end

endmodule

// File: rtl/maze_walker.sv
// Wall-following maze explorer driving a synchronous maze memory.
// Optional step-limit watchdog and steps port: define MAZE_WATCHDOG_EN.
module maze_walker
    import maze_pkg::*;
#(
    parameter int MAZE_WIDTH = 6,
    parameter int MAZE_ROWS  = 64,
    parameter int MAZE_COLS  = 64
`ifdef MAZE_WATCHDOG_EN
    ,
    parameter int MAX_STEPS  = 4095
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  hand_sel,
    input  logic [MAZE_WIDTH-1:0] starting_row,
    input  logic [MAZE_WIDTH-1:0] starting_col,
    input  logic                  maze_in,
    output logic [MAZE_WIDTH-1:0] row,
    output logic [MAZE_WIDTH-1:0] col,
    output logic                  maze_oe,
    output logic                  maze_we,
    output logic                  busy,
    output logic                  done,
    output logic                  fail
`ifdef MAZE_WATCHDOG_EN
    ,
    output logic [15:0]           steps
`endif
);

    localparam logic [MAZE_WIDTH-1:0] LAST_ROW = MAZE_WIDTH'(MAZE_ROWS - 1);
    localparam logic [MAZE_WIDTH-1:0] LAST_COL = MAZE_WIDTH'(MAZE_COLS - 1);

    state_t                state, state_d;
    logic [MAZE_WIDTH-1:0] cur_row, cur_col, cur_row_d, cur_col_d;
    logic [1:0]            heading, heading_d, attempt, attempt_d, cand_dir_q;
    logic                  hand, hand_d, moved, moved_d;
    logic [MAZE_WIDTH-1:0] cand_row, cand_col;
    logic [1:0]            cand_dir;
    logic                  off_grid, on_border, limit;

`ifdef MAZE_WATCHDOG_EN
    logic [15:0] steps_q, steps_d;
    assign limit = (steps_q >= 16'(MAX_STEPS));
    assign steps = steps_q;
`else
    assign limit = 1'b0;
`endif

    assign on_border = (cur_row == '0) || (cur_row == LAST_ROW) ||
                       (cur_col == '0) || (cur_col == LAST_COL);

    // Evaluated on next-cycle values so the address/read strobe can be registered.
    maze_dir_sel #(
        .MAZE_WIDTH(MAZE_WIDTH),
        .MAZE_ROWS (MAZE_ROWS),
        .MAZE_COLS (MAZE_COLS)
    ) u_dir_sel (
        .cur_row (cur_row_d),
        .cur_col (cur_col_d),
        .heading (heading_d),
        .attempt (attempt_d),
        .hand    (hand_d),
        .cand_row(cand_row),
        .cand_col(cand_col),
        .cand_dir(cand_dir),
        .off_grid(off_grid)
    );

    always_comb begin
        state_d   = state;
        cur_row_d = cur_row;
        cur_col_d = cur_col;
        heading_d = heading;
        attempt_d = attempt;
        hand_d    = hand;
        moved_d   = moved;
`ifdef MAZE_WATCHDOG_EN
        steps_d   = steps_q;
`endif
        case (state)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    state_d   = MARK;
                    cur_row_d = starting_row;
                    cur_col_d = starting_col;
                    heading_d = DIR_E;
                    attempt_d = 2'd0;
                    hand_d    = hand_sel;
                    moved_d   = 1'b0;
`ifdef MAZE_WATCHDOG_EN
                    steps_d   = 16'd0;
`endif
                end
            end
            MARK: begin
                attempt_d = 2'd0;
                if (on_border && moved) state_d = DONE;
                else if (limit)         state_d = FAIL;
                else                    state_d = PROBE;
            end
            PROBE: begin
                // maze_oe low here means the candidate was off-grid: treat as wall.
                if (maze_oe)               state_d = EVAL;
                else if (attempt == 2'd3)  state_d = FAIL;
                else                       attempt_d = attempt + 2'd1;
            end
            EVAL: begin
                if (!maze_in) begin
                    state_d   = MARK;
                    cur_row_d = row;
                    cur_col_d = col;
                    heading_d = cand_dir_q;
                    moved_d   = 1'b1;
`ifdef MAZE_WATCHDOG_EN
                    steps_d   = steps_q + 16'd1;
`endif
                end else if (attempt == 2'd3) begin
                    state_d = FAIL;
                end else begin
                    state_d   = PROBE;
                    attempt_d = attempt + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_row <= '0;
            cur_col <= '0;
            heading <= DIR_E;
            attempt <= 2'd0;
            hand    <= 1'b0;
            moved   <= 1'b0;
`ifdef MAZE_WATCHDOG_EN
            steps_q <= 16'd0;
`endif
        end else begin
            state   <= state_d;
            cur_row <= cur_row_d;
            cur_col <= cur_col_d;
            heading <= heading_d;
            attempt <= attempt_d;
            hand    <= hand_d;
            moved   <= moved_d;
`ifdef MAZE_WATCHDOG_EN
            steps_q <= steps_d;
`endif
        end
    end

    // Memory-side outputs; row/col hold their last value outside MARK/PROBE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row        <= '0;
            col        <= '0;
            maze_oe    <= 1'b0;
            maze_we    <= 1'b0;
            cand_dir_q <= DIR_E;
        end else begin
            maze_we <= (state_d == MARK);
            maze_oe <= (state_d == PROBE) && !off_grid;
            if (state_d == MARK) begin
                row <= cur_row_d;
                col <= cur_col_d;
            end else if ((state_d == PROBE) && !off_grid) begin
                row        <= cand_row;
                col        <= cand_col;
                cand_dir_q <= cand_dir;
            end
        end
    end

    assign busy = (state == MARK) || (state == PROBE) || (state == EVAL);
    assign done = (state == DONE);
    assign fail = (state == FAIL);

endmodule

// File: tb/tb_maze_walker.sv
// Directed bench for maze_walker on an 8x8 grid with a behavioural maze memory.
module tb_maze_walker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       hand_sel = 1'b0;
    logic [2:0] starting_row = '0;
    logic [2:0] starting_col = '0;
    logic       maze_in = 1'b0;
    logic [2:0] row, col;
    logic       maze_oe, maze_we, busy, done, fail;
`ifdef MAZE_WATCHDOG_EN
    logic [15:0] steps;
`endif

    always #5 clk = ~clk;

    maze_walker #(
        .MAZE_WIDTH(3),
        .MAZE_ROWS (8),
        .MAZE_COLS (8)
`ifdef MAZE_WATCHDOG_EN
        ,
        .MAX_STEPS (20)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .hand_sel    (hand_sel),
        .starting_row(starting_row),
        .starting_col(starting_col),
        .maze_in     (maze_in),
        .row         (row),
        .col         (col),
        .maze_oe     (maze_oe),
        .maze_we     (maze_we),
        .busy        (busy),
        .done        (done),
        .fail        (fail)
`ifdef MAZE_WATCHDOG_EN
        ,
        .steps       (steps)
`endif
    );

    // Maze memory (1 = wall) plus read/write logs; addresses are {row,col}.
    logic       walls [8][8];
    logic [5:0] rd_q[$];
    logic [5:0] wr_q[$];
    int         overlap = 0;

    always @(posedge clk) begin
        if (maze_oe) begin
            maze_in <= walls[row][col];
            rd_q.push_back({row, col});
        end
        if (maze_we) wr_q.push_back({row, col});
        if (maze_oe && maze_we) overlap++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic open_cell(input int r, input int c);
        walls[r][c] = 1'b0;
    endtask

    task automatic load_maze(input int id);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                walls[r][c] = 1'b1;
        case (id)
            0: begin  // corridor east from (3,3), corridor north from (3,3)
                open_cell(3, 3); open_cell(3, 4); open_cell(3, 5); open_cell(3, 6); open_cell(3, 7);
                open_cell(2, 3); open_cell(1, 3); open_cell(0, 3);
            end
            1: open_cell(5, 5);
            2: begin
                open_cell(0, 4); open_cell(1, 4); open_cell(1, 5); open_cell(1, 6); open_cell(1, 7);
            end
            default: begin  // ring around a single-cell island, no exit
                for (int r = 2; r <= 4; r++)
                    for (int c = 2; c <= 4; c++)
                        open_cell(r, c);
                walls[3][3] = 1'b1;
            end
        endcase
    endtask

    // Pulses start, scrambles the capture inputs afterwards, optionally re-pulses
    // start while busy at cycle glitch_at, and counts cycles until done/fail.
    task automatic run_walk(input logic [2:0] sr, input logic [2:0] sc, input logic h,
                            input int glitch_at, output int cyc, output logic we1);
        @(negedge clk);
        starting_row = sr;
        starting_col = sc;
        hand_sel     = h;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        starting_row = ~sr;
        starting_col = ~sc;
        hand_sel     = ~h;
        cyc = 0;
        we1 = 1'b0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = (cyc == glitch_at);
            if (cyc == 1) we1 = maze_we && busy;
            if (done || fail) break;
        end
        start = 1'b0;
    endtask

    typedef struct {
        int         maze;
        logic [2:0] sr;
        logic [2:0] sc;
        logic       hand;
        logic       exp_done;
        logic       exp_fail;
        logic [5:0] exp_pos;
        int         exp_cyc;
        int         exp_rd;
        logic [5:0] exp_first;
        logic [5:0] forbid;
        int         n_path;
        logic [5:0] path [8];
    } vec_t;

    vec_t tv [5];

    task automatic check_walk(input string tag, input vec_t v, input int rb, input int wb,
                              input int ov0, input int cyc, input logic we1);
        int         mism;
        int         nforbid;
        logic [5:0] first;
        chk({tag, ".cycles"}, cyc, v.exp_cyc);
        chk({tag, ".done"}, done, v.exp_done);
        chk({tag, ".fail"}, fail, v.exp_fail);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".we_at_mark"}, we1, 1);
        if (!v.exp_fail) chk({tag, ".exit"}, {row, col}, v.exp_pos);
        chk({tag, ".reads"}, rd_q.size() - rb, v.exp_rd);
        first = (rd_q.size() > rb) ? rd_q[rb] : 6'bx;
        chk({tag, ".first_read"}, first, v.exp_first);
        nforbid = 0;
        for (int j = rb; j < rd_q.size(); j++)
            if (rd_q[j] == v.forbid) nforbid++;
        chk({tag, ".forbidden_read"}, nforbid, 0);
        chk({tag, ".writes"}, wr_q.size() - wb, v.n_path);
        mism = 0;
        for (int j = 0; j < v.n_path; j++)
            if ((wb + j >= wr_q.size()) || (wr_q[wb + j] !== v.path[j])) mism++;
        chk({tag, ".path"}, mism, 0);
        chk({tag, ".oe_we_overlap"}, overlap - ov0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         cyc, rb, wb, ov0, k;
        logic       we1;
        tv[0] = '{maze: 0, sr: 3'd3, sc: 3'd3, hand: 1'b0, exp_done: 1'b1, exp_fail: 1'b0,
                  exp_pos: 6'o37, exp_cyc: 22, exp_rd: 8, exp_first: 6'o43, forbid: 6'o23,
                  n_path: 5, path: '{6'o33, 6'o34, 6'o35, 6'o36, 6'o37, 6'o0, 6'o0, 6'o0}};
        tv[1] = '{maze: 0, sr: 3'd3, sc: 3'd3, hand: 1'b1, exp_done: 1'b1, exp_fail: 1'b0,
                  exp_pos: 6'o03, exp_cyc: 15, exp_rd: 5, exp_first: 6'o23, forbid: 6'o43,
                  n_path: 4, path: '{6'o33, 6'o23, 6'o13, 6'o03, 6'o0, 6'o0, 6'o0, 6'o0}};
        tv[2] = '{maze: 1, sr: 3'd5, sc: 3'd5, hand: 1'b0, exp_done: 1'b0, exp_fail: 1'b1,
                  exp_pos: 6'o00, exp_cyc: 10, exp_rd: 4, exp_first: 6'o65, forbid: 6'o77,
                  n_path: 1, path: '{6'o55, 6'o0, 6'o0, 6'o0, 6'o0, 6'o0, 6'o0, 6'o0}};
        tv[3] = '{maze: 2, sr: 3'd0, sc: 3'd4, hand: 1'b1, exp_done: 1'b1, exp_fail: 1'b0,
                  exp_pos: 6'o17, exp_cyc: 21, exp_rd: 7, exp_first: 6'o05, forbid: 6'o74,
                  n_path: 5, path: '{6'o04, 6'o14, 6'o15, 6'o16, 6'o17, 6'o0, 6'o0, 6'o0}};
        tv[4] = '{maze: 2, sr: 3'd0, sc: 3'd4, hand: 1'b0, exp_done: 1'b1, exp_fail: 1'b0,
                  exp_pos: 6'o17, exp_cyc: 22, exp_rd: 8, exp_first: 6'o14, forbid: 6'o74,
                  n_path: 5, path: '{6'o04, 6'o14, 6'o15, 6'o16, 6'o17, 6'o0, 6'o0, 6'o0}};

        load_maze(0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", {row, col, maze_oe, maze_we, busy, done, fail}, 0);
`ifdef MAZE_WATCHDOG_EN
        chk("reset_steps", steps, 0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_quiet", {maze_oe, maze_we, busy, done, fail}, 0);

        for (int i = 0; i < 5; i++) begin
            load_maze(tv[i].maze);
            rb  = rd_q.size();
            wb  = wr_q.size();
            ov0 = overlap;
            run_walk(tv[i].sr, tv[i].sc, tv[i].hand, 0, cyc, we1);
            check_walk($sformatf("vec%0d", i), tv[i], rb, wb, ov0, cyc, we1);
        end

        // done stays asserted until the next start
        repeat (3) @(negedge clk);
        chk("done_sticky", {done, busy}, 2'b10);

        // Reset asserted while a read result is being evaluated
        load_maze(0);
        @(negedge clk);
        starting_row = 3'd3; starting_col = 3'd3; hand_sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!maze_oe && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("probe_seen_before_reset", maze_oe, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("reset_in_eval", {row, col, maze_oe, maze_we, busy, done, fail}, 0);
        rb = rd_q.size();
        wb = wr_q.size();
        repeat (3) @(negedge clk);
        chk("no_access_in_reset", (rd_q.size() - rb) + (wr_q.size() - wb), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_release", {row, col, maze_oe, maze_we, busy, done, fail}, 0);

        // Clean restart; a start pulse while busy must not disturb the walk
        rb  = rd_q.size();
        wb  = wr_q.size();
        ov0 = overlap;
        run_walk(3'd3, 3'd3, 1'b0, 5, cyc, we1);
        check_walk("restart_busy_start", tv[0], rb, wb, ov0, cyc, we1);

`ifdef MAZE_WATCHDOG_EN
        load_maze(3);
        wb = wr_q.size();
        run_walk(3'd2, 3'd2, 1'b0, 0, cyc, we1);
        chk("wd.fail", fail, 1);
        chk("wd.done", done, 0);
        chk("wd.busy", busy, 0);
        chk("wd.steps", steps, 20);
        chk("wd.writes", wr_q.size() - wb, 21);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
